arm_multicycle_controller: RTL and testbench

- Control FSM for the multicycle ARM datapath: one shared ALU, one unified instruction/data memory port, and an external instruction register (IR) that feeds the Op/Funct/Rd/Cond fields.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates all datapath mux selects and write strobes.
- Holds the NZCV flags register and evaluates condition codes.
- Stalls on a memory-ready handshake.

---
 rtl/arm_multicycle_controller.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: main sequencing FSM, ALU decoder, NZCV flag
// register and condition-code evaluation for a shared-ALU / unified-memory datapath.
module arm_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               RegWrite,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] flags_r;
    logic       cond_ex_r;

    logic       imm_bit_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic       is_cmp_s;
    logic       rd_pc_s;
    logic [1:0] alu_dec_s;
    logic       alu_arith_s;
    logic       flag_upd_s;

    logic       pc_write_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;

    // Flags are {N,Z,C,V}; 1111 is the "never" encoding.
    function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: condcheck = z;
            4'b0001: condcheck = ~z;
            4'b0010: condcheck = c;
            4'b0011: condcheck = ~c;
            4'b0100: condcheck = n;
            4'b0101: condcheck = ~n;
            4'b0110: condcheck = v;
            4'b0111: condcheck = ~v;
            4'b1000: condcheck = c & ~z;
            4'b1001: condcheck = ~c | z;
            4'b1010: condcheck = (n == v);
            4'b1011: condcheck = (n != v);
            4'b1100: condcheck = ~z & (n == v);
            4'b1101: condcheck = z | (n != v);
            4'b1110: condcheck = 1'b1;
            default: condcheck = 1'b0;
        endcase
    endfunction

    assign imm_bit_s = Funct[5];
    assign cmd_s     = Funct[4:1];
    assign s_bit_s   = Funct[0];
    assign is_cmp_s  = (cmd_s == CMD_CMP);
    assign rd_pc_s   = (Rd == 4'b1111);

    // ALU operation decode from the data-processing command field.
    always_comb begin
        alu_dec_s = ALU_ADD;
        case (cmd_s)
            CMD_ADD: alu_dec_s = ALU_ADD;
            CMD_SUB: alu_dec_s = ALU_SUB;
            CMD_AND: alu_dec_s = ALU_AND;
            CMD_ORR: alu_dec_s = ALU_ORR;
            CMD_CMP: alu_dec_s = ALU_SUB;
            default: alu_dec_s = ALU_ADD;
        endcase
    end

    assign alu_arith_s = ~alu_dec_s[1];
    assign flag_upd_s  = ((state_r == S_EXECR) || (state_r == S_EXECI)) &&
                         cond_ex_r && (s_bit_s || is_cmp_s);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Condition result latched in DECODE and used by every later strobe of the instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cond_ex_r <= 1'b0;
        end else if (state_r == S_DECODE) begin
            cond_ex_r <= condcheck(Cond, flags_r);
        end else begin
            cond_ex_r <= cond_ex_r;
        end
    end

    // NZCV register; logical ops leave C and V untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r <= 4'b0000;
        end else if (flag_upd_s) begin
            flags_r[3:2] <= ALUFlags[3:2];
            if (alu_arith_s) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end else begin
                flags_r[1:0] <= flags_r[1:0];
            end
        end else begin
            flags_r <= flags_r;
        end
    end

    // Next-state logic; unused encodings recover to FETCH.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_MEM: state_nxt_s = S_MEMADR;
                    OP_DP: begin
                        if (imm_bit_s) begin
                            state_nxt_s = S_EXECI;
                        end else begin
                            state_nxt_s = S_EXECR;
                        end
                    end
                    OP_BR:   state_nxt_s = S_BRANCH;
                    default: state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (s_bit_s) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWB:  state_nxt_s = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXECR, S_EXECI: begin
                if (is_cmp_s) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_ALUWB;
                end
            end
            S_ALUWB:  state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // Per-state datapath selects and raw write strobes.
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = cond_ex_r;
                pc_write_s  = cond_ex_r & rd_pc_s;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                mem_write_s = cond_ex_r;
            end
            S_EXECR: begin
                ALUControl = alu_dec_s;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec_s;
            end
            S_ALUWB: begin
                reg_write_s = cond_ex_r & ~is_cmp_s;
                pc_write_s  = cond_ex_r & ~is_cmp_s & rd_pc_s;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_s = cond_ex_r;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Reset suppresses every architectural write, even mid-instruction.
    always_comb begin
        PCWrite  = pc_write_s  & rst_n;
        IRWrite  = ir_write_s  & rst_n;
        MemWrite = mem_write_s & rst_n;
        RegWrite = reg_write_s & rst_n;
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
    assign state  = state_r;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench for arm_multicycle_controller: each scenario queues
// per-cycle stimulus and the expected state/strobes, then replays and checks them.
module tb_arm_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] state;

    arm_multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .RegWrite(RegWrite), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4;
    localparam logic [3:0] MW = 4'd5, XR = 4'd6, XI = 4'd7, AW = 4'd8, BR = 4'd9;

    // stb = {PCWrite, IRWrite, MemWrite, RegWrite}
    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [3:0] af;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] cond;
        logic [3:0] st;
        logic [3:0] stb;
        logic [1:0] aluc;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic [3:0] cur_rd;
    logic [3:0] cur_cond;

    // Expected {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} for each state.
    function automatic logic [5:0] sel_ref(input logic [3:0] st);
        case (st)
            FE, DE:  sel_ref = 6'b0_10_1_10;
            MA:      sel_ref = 6'b0_00_0_01;
            MR, MW:  sel_ref = 6'b1_00_0_00;
            MB:      sel_ref = 6'b0_01_0_00;
            XI:      sel_ref = 6'b0_00_0_01;
            BR:      sel_ref = 6'b0_10_0_01;
            default: sel_ref = 6'b0_00_0_00;
        endcase
    endfunction

    task automatic set_ir(input logic [1:0] op, input logic [5:0] funct,
                          input logic [3:0] rd, input logic [3:0] cond);
        cur_op = op; cur_funct = funct; cur_rd = rd; cur_cond = cond;
    endtask

    task automatic pc(input logic rst, input logic rdy, input logic [3:0] af,
                      input logic [3:0] st, input logic [3:0] stb, input logic [1:0] aluc);
        exp_t e;
        e.rst = rst; e.rdy = rdy; e.af = af; e.op = cur_op; e.funct = cur_funct;
        e.rd = cur_rd; e.cond = cur_cond; e.st = st; e.stb = stb; e.aluc = aluc;
        sb.push_back(e);
    endtask

    task automatic push_cmp(input logic [3:0] af);
        set_ir(2'b00, 6'b010101, 4'd0, 4'b1110);
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, af,      XR, 4'b0000, 2'b01);
    endtask

    task automatic push_branch(input logic [3:0] cond, input logic taken);
        set_ir(2'b10, 6'b000000, 4'd0, cond);
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, BR, {taken, 3'b000}, 2'b00);
    endtask

    task automatic push_dp(input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] af,
                           input logic [1:0] aluc, input logic [3:0] wb_stb);
        set_ir(2'b00, funct, rd, 4'b1110);
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, af, funct[5] ? XI : XR, 4'b0000, aluc);
        pc(1'b1, 1'b1, 4'b0000, AW, wb_stb, 2'b00);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [19:0] got, want;
        set_ir(2'b00, 6'b000000, 4'd0, 4'b1110);
        pc(1'b0, 1'b1, 4'b0000, FE, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
            Op = e.op; Funct = e.funct; Rd = e.rd; Cond = e.cond;
            @(negedge clk);
            got  = {state, PCWrite, IRWrite, MemWrite, RegWrite, ALUControl,
                    AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};
            want = {e.st, e.stb, e.aluc, sel_ref(e.st), e.op, e.op == 2'b01, e.op == 2'b10};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset: got %b expected %b", got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dp();
        exp_t e;
        logic [19:0] got, want;
        push_dp(6'b001000, 4'd1, 4'b0000, 2'b00, 4'b0001);   // ADD R1,R2,R3
        push_dp(6'b101000, 4'd2, 4'b0000, 2'b00, 4'b0001);   // ADD imm
        push_dp(6'b000100, 4'd3, 4'b0000, 2'b01, 4'b0001);   // SUB
        push_dp(6'b000000, 4'd4, 4'b0000, 2'b10, 4'b0001);   // AND
        push_dp(6'b011110, 4'd5, 4'b0000, 2'b00, 4'b0001);   // cmd 1111 -> add
        set_ir(2'b11, 6'b000000, 4'd0, 4'b1110);             // illegal op = NOP
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        push_cmp(4'b0000);
        push_dp(6'b001000, 4'd15, 4'b1111, 2'b00, 4'b1001);  // ADD PC (no S: flags keep)
        push_dp(6'b011001, 4'd3, 4'b1011, 2'b11, 4'b0001);   // ORRS
        push_branch(4'b0100, 1'b1);                          // MI: N=1
        push_branch(4'b0010, 1'b0);                          // CS: C held 0
        push_branch(4'b0110, 1'b0);                          // VS: V held 0
        push_branch(4'b0000, 1'b0);                          // EQ: Z=0
        push_branch(4'b1111, 1'b0);                          // never
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
            Op = e.op; Funct = e.funct; Rd = e.rd; Cond = e.cond;
            @(negedge clk);
            got  = {state, PCWrite, IRWrite, MemWrite, RegWrite, ALUControl,
                    AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};
            want = {e.st, e.stb, e.aluc, sel_ref(e.st), e.op, e.op == 2'b01, e.op == 2'b10};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL dp: got %b expected %b", got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldr();
        exp_t e;
        logic [19:0] got, want;
        set_ir(2'b01, 6'b011001, 4'd2, 4'b1110);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MA, 4'b0000, 2'b00);
        for (int i = 0; i < 3; i++) pc(1'b1, 1'b0, 4'b0000, MR, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MR, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MB, 4'b0001, 2'b00);
        set_ir(2'b01, 6'b011001, 4'd15, 4'b1110);           // LDR PC
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MA, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MR, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MB, 4'b1001, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
            Op = e.op; Funct = e.funct; Rd = e.rd; Cond = e.cond;
            @(negedge clk);
            got  = {state, PCWrite, IRWrite, MemWrite, RegWrite, ALUControl,
                    AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};
            want = {e.st, e.stb, e.aluc, sel_ref(e.st), e.op, e.op == 2'b01, e.op == 2'b10};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL ldr: got %b expected %b", got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cmp_branch();
        exp_t e;
        logic [19:0] got, want;
        push_cmp(4'b0100);
        push_branch(4'b0000, 1'b1);                          // BEQ taken
        push_branch(4'b0001, 1'b0);                          // BNE not taken
        push_cmp(4'b0000);
        push_branch(4'b0000, 1'b0);                          // BEQ not taken
        push_cmp(4'b1001);                                   // N=1 V=1: GE true, LT false
        push_branch(4'b1010, 1'b1);
        push_branch(4'b1011, 1'b0);
        push_branch(4'b1000, 1'b0);                          // HI: C=0
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
            Op = e.op; Funct = e.funct; Rd = e.rd; Cond = e.cond;
            @(negedge clk);
            got  = {state, PCWrite, IRWrite, MemWrite, RegWrite, ALUControl,
                    AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};
            want = {e.st, e.stb, e.aluc, sel_ref(e.st), e.op, e.op == 2'b01, e.op == 2'b10};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cmp_branch: got %b expected %b", got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_reset();
        exp_t e;
        logic [19:0] got, want;
        push_cmp(4'b0100);                                   // Z=1
        set_ir(2'b01, 6'b011000, 4'd1, 4'b0001);             // STRNE: suppressed
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MA, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MW, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        set_ir(2'b01, 6'b011000, 4'd1, 4'b1110);             // STR with wait
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MA, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, MW, 4'b0010, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, MW, 4'b0010, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MW, 4'b0010, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, FE, 4'b1100, 2'b00);         // STR, reset in MEMWR
        pc(1'b1, 1'b1, 4'b0000, DE, 4'b0000, 2'b00);
        pc(1'b1, 1'b1, 4'b0000, MA, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, MW, 4'b0010, 2'b00);
        pc(1'b0, 1'b0, 4'b0000, MW, 4'b0000, 2'b00);
        pc(1'b1, 1'b0, 4'b0000, FE, 4'b0000, 2'b00);
        push_branch(4'b0000, 1'b0);                          // flags cleared: EQ false
        push_branch(4'b0001, 1'b1);                          // NE true
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
            Op = e.op; Funct = e.funct; Rd = e.rd; Cond = e.cond;
            @(negedge clk);
            got  = {state, PCWrite, IRWrite, MemWrite, RegWrite, ALUControl,
                    AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};
            want = {e.st, e.stb, e.aluc, sel_ref(e.st), e.op, e.op == 2'b01, e.op == 2'b10};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL store_reset: got %b expected %b", got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; ALUFlags = 4'b0000;
        Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; Cond = 4'b1110;
        @(posedge clk); #1;
        test_reset();
        test_dp();
        test_ldr();
        test_cmp_branch();
        test_store_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
